// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (round-to-nearest-even).
// Subnormal operands are flushed to zero. A single global enable stalls all stages.
module fp_mul_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [EXP_W+MAN_W:0]     q,
    output logic [3:0]               flags,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * SW;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // Global advance enable: the output register is free or being drained
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage registers
    logic                 s1_valid;
    cls_e                 s1_cls;
    logic                 s1_sign;
    logic signed [EW-1:0] s1_exp;
    logic [SW-1:0]        s1_ma;
    logic [SW-1:0]        s1_mb;

    logic                 s2_valid;
    cls_e                 s2_cls;
    logic                 s2_sign;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;

    // Stage 1 combinational: field extraction and operand classification
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    cls_e             cls_in;

    // Classify operands and pick the special-case class with NaN > Inf > Zero priority
    always_comb begin
        ea     = a[W-2 -: EXP_W];
        eb     = b[W-2 -: EXP_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (fa == '0);
        b_inf  = (&eb) && (fb == '0);
        a_nan  = (&ea) && (fa != '0);
        b_nan  = (&eb) && (fb != '0);
        cls_in = CLS_NORM;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            cls_in = CLS_NAN;
        end else if (a_inf || b_inf) begin
            cls_in = CLS_INF;
        end else if (a_zero || b_zero) begin
            cls_in = CLS_ZERO;
        end
    end

    // Stage 3 combinational: normalise, round, pack and flag
    logic                 top;
    logic [PW-2:0]        norm;
    logic [MAN_W-1:0]     man;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [SW-1:0]        man_r;
    logic signed [EW-1:0] e_fin;
    logic                 inexact;
    logic [W-1:0]         q_next;
    logic [3:0]           flags_next;

    // Product in [1,4): shift so the leading one is dropped at bit PW-1
    always_comb begin
        top        = s2_prod[PW-1];
        norm       = top ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
        man        = norm[PW-2 -: MAN_W];
        guard      = norm[PW-2-MAN_W];
        sticky     = |norm[PW-3-MAN_W:0];
        round_up   = guard && (sticky || man[0]);
        man_r      = {1'b0, man} + SW'(round_up);
        e_fin      = s2_exp + EW'(top) + EW'(man_r[MAN_W]);
        inexact    = guard || sticky;
        q_next     = '0;
        flags_next = 4'b0000;
        case (s2_cls)
            CLS_NAN: begin
                q_next     = {1'b0, {EXP_W{1'b1}}, 1'b1, (MAN_W-1)'(0)};
                flags_next = 4'b1000;
            end
            CLS_INF: begin
                q_next = {s2_sign, {EXP_W{1'b1}}, MAN_W'(0)};
            end
            CLS_ZERO: begin
                q_next = {s2_sign, (W-1)'(0)};
            end
            default: begin
                if (e_fin >= $signed(EW'(EMAX))) begin
                    q_next     = {s2_sign, {EXP_W{1'b1}}, MAN_W'(0)};
                    flags_next = 4'b0101;
                end else if (e_fin <= $signed(EW'(0))) begin
                    q_next     = {s2_sign, (W-1)'(0)};
                    flags_next = 4'b0011;
                end else begin
                    q_next     = {s2_sign, e_fin[EXP_W-1:0], man_r[MAN_W-1:0]};
                    flags_next = {3'b000, inexact};
                end
            end
        endcase
    end

    // Valid bits and output register: cleared asynchronously, advance on en
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            q         <= '0;
            flags     <= 4'b0000;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            q         <= q_next;
            flags     <= flags_next;
        end
    end

    // Datapath stage registers, no reset needed
    always_ff @(posedge clk) begin
        if (en) begin
            s1_cls  <= cls_in;
            s1_sign <= a[W-1] ^ b[W-1];
            s1_exp  <= EW'(ea) + EW'(eb) - EW'(BIAS);
            s1_ma   <= {1'b1, fa};
            s1_mb   <= {1'b1, fb};
            s2_cls  <= s1_cls;
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_prod <= PW'(s1_ma) * PW'(s1_mb);
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Testbench for fp_mul_pipe: directed steps, queue scoreboard, stall and reset scenarios.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset_n;
    logic [31:0] a, b, q;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  flags;

    logic [15:0] a2, b2, q2;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [3:0]  flags2;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .areset_n(areset_n), .a(a), .b(b), .in_valid(in_valid),
        .in_ready(in_ready), .q(q), .flags(flags), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .areset_n(areset_n), .a(a2), .b(b2), .in_valid(in_valid2),
        .in_ready(in_ready2), .q(q2), .flags(flags2), .out_valid(out_valid2),
        .out_ready(out_ready2)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [3:0]  f;
        logic [15:0] id;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur_exp;
    int          errors, checks, cycle, stall_cnt, acc_in_stall;
    int          last_pop, prev_pop, next_id, lat;
    logic        last_acc, held_v;
    logic [31:0] held_q;
    logic [3:0]  held_f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
        end
    endtask

    // Exact single-precision encoding of a small positive integer
    function automatic logic [31:0] int2fp(input int unsigned n);
        int unsigned p = 0;
        logic [31:0] m;
        for (int i = 0; i < 24; i++) begin
            if (n[i]) p = i;
        end
        m = n << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // One clock: sample at negedge (scoreboard, stall checks), then advance
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            sb.push_back(cur_exp);
            if (!out_ready) acc_in_stall++;
        end
        if (sb.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else if (out_valid && out_ready) begin
            e = sb.pop_front();
            check($sformatf("q[%0d]", e.id), q, e.q);
            check($sformatf("flags[%0d]", e.id), 32'(flags), 32'(e.f));
            prev_pop = last_pop;
            last_pop = cycle;
        end
        if (out_valid && !out_ready) begin
            check("in_ready_stall", 32'(in_ready), 32'd0);
            if (held_v) begin
                check("q_hold", q, held_q);
                check("flags_hold", 32'(flags), 32'(held_f));
            end else begin
                held_q = q;
                held_f = flags;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
        @(posedge clk);
        cycle++;
        #1;
        if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) out_ready = 1'b1;
        end
    endtask

    // Present an operand pair and hold it until accepted; leaves in_valid high
    task automatic send(input logic [31:0] ta, input logic [31:0] tb2,
                        input logic [31:0] eq, input logic [3:0] ef);
        a        = ta;
        b        = tb2;
        in_valid = 1'b1;
        cur_exp  = '{q: eq, f: ef, id: 16'(next_id)};
        next_id++;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (last_acc) return;
        end
        check("send_timeout", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic measure(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                           input logic [31:0] eq, input logic [3:0] ef);
        send(ta, tb2, eq, ef);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check(tag, 32'(lat), 32'd3);
        drain();
    endtask

    initial begin
        areset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        a2 = '0; b2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        errors = 0; checks = 0; cycle = 0; stall_cnt = 0; acc_in_stall = 0;
        last_pop = 0; prev_pop = 0; next_id = 0; lat = 0;
        last_acc = 1'b0; held_v = 1'b0; held_q = '0; held_f = '0; cur_exp = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_out_valid_h", 32'(out_valid2), 32'd0);
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // 0.1 x 0.2 with latency measurement
        measure("lat_basic", 32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3CA3D70B, 4'b0001);

        // Back-to-back
        send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        send(32'h40000000, 32'hC0400000, 32'hC0C00000, 4'b0000);
        drain();
        check("b2b_consecutive", 32'(last_pop - prev_pop), 32'd1);

        // Specials
        send(32'hFFFFFFFA, 32'hFFFFFFFA, 32'h7FC00000, 4'b1000);
        send(32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000);
        send(32'h00000002, 32'h00000017, 32'h00000000, 4'b0000);
        send(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
        send(32'h80000000, 32'h40400000, 32'h80000000, 4'b0000);
        drain();

        // Range
        send(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
        send(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        drain();

        // Backpressure: 5 stalled cycles while 10 pairs are offered continuously
        out_ready    = 1'b0;
        stall_cnt    = 5;
        acc_in_stall = 0;
        for (int i = 0; i < 10; i++) begin
            send(int2fp(i + 1), int2fp(i + 3), int2fp((i + 1) * (i + 3)), 4'b0000);
        end
        drain();
        check("accepted_before_full", 32'(acc_in_stall), 32'd3);

        // Reset with two operations in flight
        send(int2fp(3), int2fp(5), int2fp(15), 4'b0000);
        send(int2fp(7), int2fp(9), int2fp(63), 4'b0000);
        in_valid = 1'b0;
        areset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_q", q, 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        repeat (4) tick();
        check("in_ready_after_midrst", 32'(in_ready), 32'd1);
        measure("lat_after_rst", int2fp(6), int2fp(11), int2fp(66), 4'b0000);

        // Half-precision instance
        check("h_in_ready", 32'(in_ready2), 32'd1);
        a2 = 16'h3E00;
        b2 = 16'h4000;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        lat = 1;
        while (!out_valid2 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("h_latency", 32'(lat), 32'd3);
        check("h_q", 32'(q2), 32'h4200);
        check("h_flags", 32'(flags2), 32'd0);

        check("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width in bits.
REQ-002 Parameter MAN_W, default 23, stored fraction field width in bits.
REQ-003 Derived W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1, both fixed and not overridable.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port areset_n, input, 1, asynchronous active-low reset.
REQ-006 Port a, input, W, operand A as {sign, exponent, fraction}.
REQ-007 Port b, input, W, operand B in the same format.
REQ-008 Port in_valid, input, 1, a/b valid this cycle.
REQ-009 Port in_ready, output, 1, block accepts an operand pair this cycle.
REQ-010 Port q, output, W, product.
REQ-011 Port flags, output, 4, bit order {nan, overflow, underflow, inexact}, qualified by out_valid.
REQ-012 Port out_valid, output, 1, q/flags valid.
REQ-013 Port out_ready, input, 1, consumer accepts q/flags this cycle.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 Three-stage pipeline: S1 unpack/classify, sign XOR, exponent sum; S2 significand product; S3 normalise, round, pack, flags.
REQ-016 Latency is 3 cycles from input transfer to out_valid, with no stall.
REQ-017 Throughput is one operation per cycle when out_ready=1.
REQ-018 Global advance enable en = !out_valid || out_ready; all stages hold when en=0; in_ready = en (combinational).
REQ-019 Each stage carries a valid bit; bubbles propagate and never assert out_valid.
REQ-020 Results leave in input order; no operation is dropped or duplicated under any out_ready pattern.
REQ-021 Operands with exponent 0 (zero or subnormal) are treated as zero with their sign kept; this raises no flag.
REQ-022 Exponent arithmetic is signed, EXP_W+2 bits: e = ea+eb-BIAS, incremented by 1 when the significand product is >= 2.
REQ-023 Rounding is round-to-nearest-even on the (MAN_W+1)x(MAN_W+1) product; a mantissa carry-out from rounding increments e.
REQ-024 inexact = 1 when any discarded product bit is nonzero.
REQ-025 NaN result when either operand is NaN, or for zero x Inf: q = canonical quiet NaN {0, all-ones exponent, fraction MSB 1, rest 0}; nan=1; other flags 0.
REQ-026 Inf x finite nonzero gives Inf with the XOR sign and no flags.
REQ-027 Zero x finite gives zero with the XOR sign and no flags.
REQ-028 Overflow (final e >= 2^EXP_W-1) gives signed Inf, with overflow=1 and inexact=1.
REQ-029 Underflow (final e <= 0) gives signed zero, with underflow=1 and inexact=1.
REQ-030 q and flags hold stable while out_valid && !out_ready.

Reset
REQ-031 When areset_n=0: all stage valid bits clear immediately (asynchronous); out_valid=0, q=0, flags=0.
REQ-032 in_ready=1 from the first cycle after reset release.
REQ-033 Operations in flight at reset are discarded; after release, the first result appears 3 cycles after the first new input transfer.
REQ-034 Datapath registers other than valid bits and output registers need no reset.

Verification
REQ-035 Defaults; a=0x3DCCCCCD (0.1), b=0x3E4CCCCD (0.2), out_ready=1 -> 3 cycles later q=0x3CA3D70B, flags=0001.
REQ-036 Back-to-back: 1.5x1.5 (0x3FC00000 twice), then a=0x40000000 (2.0), b=0xC0400000 (-3.0), out_ready=1 -> q=0x40100000 then 0xC0C00000 on consecutive cycles, flags=0000 for both.
REQ-037 Specials: a=b=0xFFFFFFFA -> q=0x7FC00000, flags=1000; a=0x00000000, b=0xFF800000 -> q=0x7FC00000, flags=1000; a=0x00000002, b=0x00000017 (subnormals) -> q=0x00000000, flags=0000.
REQ-038 Range: a=0x7F000000, b=0x40000000 -> q=0x7F800000, flags=0101; a=0x00800000, b=0x3F000000 -> q=0x00000000, flags=0011.
REQ-039 Backpressure: continuous in_valid with 10 distinct operand pairs and out_ready=0 for 5 cycles -> in_ready falls once 3 results are held, and all 10 results emerge in order with no loss.
REQ-040 Reset mid-flight: areset_n=0 asserted with 2 ops in flight -> out_valid=0 immediately, no stale result after release, next op latency 3.
REQ-041 Parameter sweep: EXP_W=5, MAN_W=10; a=0x3E00 (1.5), b=0x4000 (2.0) -> q=0x4200, flags=0000.
